// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared types and constants for the stopwatch digit blocks.
//   digit_t        : one BCD digit (0..9)
//   S0_MAX/S0_MIN  : range limits of the seconds-units digit
//   dir_e          : count direction
//   digit_inc_wrap : +1 modulo 10, used by set-mode manual increment
package stopwatch_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t S0_MAX = 4'd9;
   localparam digit_t S0_MIN = 4'd0;

   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

   function automatic digit_t digit_inc_wrap(input digit_t d);
      return (d == S0_MAX) ? S0_MIN : d + 4'd1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler -- divides clk down to a one-cycle step every TICK_DIV
// running cycles. Reusable for any digit rate (seconds, centiseconds).
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   run   : count enable; the phase is held while low
//   clear : synchronous clear of the phase counter (wins over run)
//   step  : high on the running cycle where the counter wraps
// Parameters: TICK_DIV (>= 2) cycles per step, CNT_W with 2^CNT_W >= TICK_DIV.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic step
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             at_last;

   assign at_last = (cnt == LAST);
   assign step    = run & at_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       cnt <= '0;
      else if (clear)   cnt <= '0;
      else if (run)     cnt <= at_last ? '0 : cnt + CNT_W'(1);
   end

endmodule

// File: rtl/s0_digit_counter.sv
// s0_digit_counter -- seconds-units digit of the stopwatch.
// Holds the 1 Hz prescaler and the 0..9 up/down digit. Emits a one-cycle
// carry/borrow to the seconds-tens digit on the same cycle its own digit
// steps, so both digits update on one edge. A sticky done flag is raised
// when a step would leave the range while the upper digits report their
// limit (upper_limit). Set mode freezes counting and allows manual +1.
// Ports:
//   clk, reset (async active-low)
//   start        : run level          ups         : 1 = up, 0 = down
//   force_reset  : sync clear         set_en      : set mode
//   plus         : set-mode +1 (edge) upper_limit : upper digits at limit
//   lap          : lap toggle request (edge)
//   out_S0       : current digit      disp_S0     : digit for display
//   carry_out    : step pulse to S1   done        : sticky limit flag
// Optional: define STOPWATCH_LAP_EN to add the lap-freeze display capture;
// without it disp_S0 follows out_S0 and lap is ignored.
module s0_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       ups,
   input  logic       force_reset,
   input  logic       set_en,
   input  logic       plus,
   input  logic       upper_limit,
   input  logic       lap,
   output logic [3:0] out_S0,
   output logic [3:0] disp_S0,
   output logic       carry_out,
   output logic       done
);

   digit_t s0_q;
   logic   done_q;
   logic   plus_q;
   logic   set_q;
   logic   run;
   logic   step;
   logic   at_end;
   logic   plus_rise;
   logic   set_rise;
   dir_e   dir;

   assign run       = start & ~set_en & ~done_q;
   assign dir       = ups ? DIR_UP : DIR_DOWN;
   assign at_end    = (dir == DIR_UP) ? (s0_q == S0_MAX) : (s0_q == S0_MIN);
   assign plus_rise = plus & ~plus_q;
   assign set_rise  = set_en & ~set_q;

   // force_reset masks the pulse so S1 never sees a carry the digit dropped.
   assign carry_out = step & ~force_reset & at_end & ~upper_limit;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .clear (force_reset | set_en),
      .step  (step)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_q   <= S0_MIN;
         done_q <= 1'b0;
         plus_q <= 1'b0;
         set_q  <= 1'b0;
      end else begin
         plus_q <= plus;
         set_q  <= set_en;
         if (force_reset) begin
            s0_q   <= S0_MIN;
            done_q <= 1'b0;
         end else if (set_en) begin
            if (plus_rise) s0_q <= digit_inc_wrap(s0_q);
            if (set_rise)  done_q <= 1'b0;
         end else if (step) begin
            if (!at_end)          s0_q   <= (dir == DIR_UP) ? s0_q + 4'd1 : s0_q - 4'd1;
            else if (upper_limit) done_q <= 1'b1;   // digit holds at its limit
            else                  s0_q   <= (dir == DIR_UP) ? S0_MIN : S0_MAX;
         end
      end
   end

   assign out_S0 = s0_q;
   assign done   = done_q;

`ifdef STOPWATCH_LAP_EN
   logic   lap_q;
   logic   lap_active;
   digit_t lap_s0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lap_q      <= 1'b0;
         lap_active <= 1'b0;
         lap_s0     <= S0_MIN;
      end else begin
         lap_q <= lap;
         if (force_reset) begin
            lap_active <= 1'b0;
         end else if (lap & ~lap_q) begin
            lap_active <= ~lap_active;
            if (!lap_active) lap_s0 <= s0_q;   // capture only when entering lap
         end
      end
   end

   assign disp_S0 = lap_active ? lap_s0 : s0_q;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign disp_S0    = s0_q;
`endif

endmodule

// File: tb/tb_s0_digit_counter.sv
module tb_s0_digit_counter;
   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset, start, ups, force_reset, set_en, plus, upper_limit, lap;
   logic [3:0] out_S0, disp_S0;
   logic       carry_out, done;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_cnt, m_s0, m_lap_val;
   bit m_done, m_plus_q, m_set_q, m_lap_q, m_lap_act;

   s0_digit_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .start(start), .ups(ups),
      .force_reset(force_reset), .set_en(set_en), .plus(plus),
      .upper_limit(upper_limit), .lap(lap), .out_S0(out_S0),
      .disp_S0(disp_S0), .carry_out(carry_out), .done(done)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_cnt = 0; m_s0 = 0; m_done = 0; m_plus_q = 0; m_set_q = 0;
      m_lap_q = 0; m_lap_act = 0; m_lap_val = 0;
   endfunction

   // a second has elapsed on this cycle
   function automatic bit m_second();
      return start && !set_en && !m_done && (m_cnt == TD - 1);
   endfunction

   function automatic bit m_carry();
      int nxt;
      nxt = m_s0 + (ups ? 1 : -1);
      return !force_reset && m_second() && (nxt < 0 || nxt > 9) && !upper_limit;
   endfunction

   function automatic int m_disp();
`ifdef STOPWATCH_LAP_EN
      return m_lap_act ? m_lap_val : m_s0;
`else
      return m_s0;
`endif
   endfunction

   function automatic void model_update();
      int  nxt;
      int  old_s0;
      bit  sec, running;
      old_s0  = m_s0;
      sec     = m_second();
      running = start && !set_en && !m_done;
      if (force_reset) begin
         m_cnt = 0; m_s0 = 0; m_done = 0;
      end else if (set_en) begin
         m_cnt = 0;
         if (plus && !m_plus_q) m_s0 = (m_s0 + 1) % 10;
         if (!m_set_q) m_done = 0;
      end else if (sec) begin
         m_cnt = 0;
         nxt = m_s0 + (ups ? 1 : -1);
         if (nxt >= 0 && nxt <= 9) m_s0 = nxt;
         else if (upper_limit)     m_done = 1;
         else                      m_s0 = (nxt + 10) % 10;
      end else if (running) begin
         m_cnt = m_cnt + 1;
      end
      if (force_reset) m_lap_act = 0;
      else if (lap && !m_lap_q) begin
         if (!m_lap_act) m_lap_val = old_s0;
         m_lap_act = !m_lap_act;
      end
      m_lap_q  = lap;
      m_plus_q = plus;
      m_set_q  = set_en;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      reset = 0; start = 0; ups = 1; force_reset = 0; set_en = 0;
      plus = 0; upper_limit = 0; lap = 0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (out_S0 !== 4'd0 || done !== 1'b0 || carry_out !== 1'b0 || disp_S0 !== 4'd0) begin
         errors++;
         $display("FAIL reset_state out=%0d done=%0b carry=%0b disp=%0d exp 0/0/0/0",
                  out_S0, done, carry_out, disp_S0);
      end
      reset = 1; start = 1;
      n = 0;
      while (!(m_s0 == 6 && m_cnt == 2) && n < 100) begin tick(); n++; end
      checks++;
      if (n >= 100 || out_S0 !== 4'd6) begin
         errors++; $display("FAIL reset_reach6 out=%0d exp 6 waited=%0d", out_S0, n);
      end
      #2 reset = 0;
      #1;
      checks++;
      if (out_S0 !== 4'd0 || carry_out !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_async out=%0d carry=%0b done=%0b exp 0/0/0", out_S0, carry_out, done);
      end
      model_reset();
      @(negedge clk);
      reset = 1;
      for (int k = 1; k <= 3; k++) begin
         repeat (3) tick();
         checks++;
         if (out_S0 !== 4'(k - 1)) begin
            errors++; $display("FAIL reset_hold got %0d exp %0d", out_S0, k - 1);
         end
         tick();
         checks++;
         if (out_S0 !== 4'(k)) begin
            errors++; $display("FAIL reset_count got %0d exp %0d", out_S0, k);
         end
      end
   endtask

   task automatic test_up_wrap();
      int n, pulses;
      ups = 1; upper_limit = 0; start = 1;
      n = 0;
      while (!(m_s0 == 9 && m_cnt == 3) && n < 200) begin tick(); n++; end
      checks++;
      if (n >= 200 || carry_out !== 1'b1) begin
         errors++; $display("FAIL up_wrap_carry got %0b exp 1 waited=%0d", carry_out, n);
      end
      tick();
      checks++;
      if (out_S0 !== 4'd0 || carry_out !== 1'b0) begin
         errors++; $display("FAIL up_wrap_next out=%0d carry=%0b exp 0/0", out_S0, carry_out);
      end
      pulses = 0;
      repeat (30) begin if (carry_out) pulses++; tick(); end
      checks++;
      if (pulses != 0 || out_S0 !== 4'd7) begin
         errors++; $display("FAIL up_wrap_after pulses=%0d out=%0d exp 0/7", pulses, out_S0);
      end
   endtask

   task automatic test_down_limit();
      int n, bad;
      force_reset = 1; tick(); force_reset = 0;
      ups = 0; start = 1; upper_limit = 0;
      n = 0;
      while (m_cnt != 3 && n < 10) begin tick(); n++; end
      checks++;
      if (carry_out !== 1'b1 || out_S0 !== 4'd0) begin
         errors++; $display("FAIL down_borrow carry=%0b out=%0d exp 1/0", carry_out, out_S0);
      end
      tick();
      checks++;
      if (out_S0 !== 4'd9) begin
         errors++; $display("FAIL down_borrow_next got %0d exp 9", out_S0);
      end
      upper_limit = 1;
      n = 0;
      while (!(m_s0 == 0 && m_cnt == 3) && n < 100) begin tick(); n++; end
      checks++;
      if (n >= 100 || carry_out !== 1'b0) begin
         errors++; $display("FAIL down_limit_carry got %0b exp 0 waited=%0d", carry_out, n);
      end
      tick();
      checks++;
      if (done !== 1'b1 || out_S0 !== 4'd0) begin
         errors++; $display("FAIL down_limit_done done=%0b out=%0d exp 1/0", done, out_S0);
      end
      bad = 0;
      repeat (20) begin
         tick();
         if (out_S0 !== 4'd0 || carry_out !== 1'b0 || done !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL down_limit_hold bad_cycles=%0d exp 0", bad);
      end
   endtask

   task automatic test_set_mode();
      int pulses;
      set_en = 1;
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL set_clear_done got %0b exp 0", done);
      end
      pulses = 0;
      repeat (12) begin
         plus = 1; if (carry_out) pulses++; tick();
         plus = 0; if (carry_out) pulses++; tick();
      end
      checks++;
      if (out_S0 !== 4'd2 || pulses != 0) begin
         errors++; $display("FAIL set_plus out=%0d pulses=%0d exp 2/0", out_S0, pulses);
      end
      set_en = 0; ups = 1; upper_limit = 0; start = 1;
      repeat (3) tick();
      checks++;
      if (out_S0 !== 4'd2) begin
         errors++; $display("FAIL set_presc_zero_hold got %0d exp 2", out_S0);
      end
      tick();
      checks++;
      if (out_S0 !== 4'd3) begin
         errors++; $display("FAIL set_presc_zero_step got %0d exp 3", out_S0);
      end
   endtask

   task automatic test_force_on_step();
      int n;
      ups = 1; upper_limit = 0; start = 1;
      n = 0;
      while (!(m_s0 == 9 && m_cnt == 3) && n < 200) begin tick(); n++; end
      force_reset = 1;
      #1;
      checks++;
      if (n >= 200 || carry_out !== 1'b0) begin
         errors++; $display("FAIL force_carry got %0b exp 0 waited=%0d", carry_out, n);
      end
      tick();
      force_reset = 0;
      checks++;
      if (out_S0 !== 4'd0 || done !== 1'b0) begin
         errors++; $display("FAIL force_next out=%0d done=%0b exp 0/0", out_S0, done);
      end
      repeat (3) tick();
      checks++;
      if (out_S0 !== 4'd0) begin
         errors++; $display("FAIL force_presc_hold got %0d exp 0", out_S0);
      end
      tick();
      checks++;
      if (out_S0 !== 4'd1) begin
         errors++; $display("FAIL force_presc_step got %0d exp 1", out_S0);
      end
   endtask

   task automatic test_lap();
      int n;
      force_reset = 1; tick(); force_reset = 0;
      ups = 1; upper_limit = 0; start = 1;
      n = 0;
      while (!(m_s0 == 3 && m_cnt == 0) && n < 100) begin tick(); n++; end
      lap = 1; tick(); lap = 0;
      repeat (7) tick();
`ifdef STOPWATCH_LAP_EN
      checks++;
      if (out_S0 !== 4'd5 || disp_S0 !== 4'd3) begin
         errors++; $display("FAIL lap_freeze out=%0d disp=%0d exp 5/3", out_S0, disp_S0);
      end
`else
      checks++;
      if (out_S0 !== 4'd5 || disp_S0 !== 4'd5) begin
         errors++; $display("FAIL lap_ignored out=%0d disp=%0d exp 5/5", out_S0, disp_S0);
      end
`endif
      lap = 1; tick(); lap = 0; tick();
      checks++;
      if (disp_S0 !== out_S0 || out_S0 !== 4'(m_s0)) begin
         errors++; $display("FAIL lap_release disp=%0d out=%0d exp %0d", disp_S0, out_S0, m_s0);
      end
   endtask

   task automatic test_random();
      int e_out, e_done, e_carry, e_disp;
      e_out = 0; e_done = 0; e_carry = 0; e_disp = 0;
      for (int i = 0; i < 3000; i++) begin
         start       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) == 0) ups = ~ups;
         force_reset = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 29) == 0) set_en = ~set_en;
         plus        = $urandom_range(0, 1);
         upper_limit = ($urandom_range(0, 3) == 0);
         lap         = ($urandom_range(0, 7) == 0);
         #1;
         checks += 4;
         if (out_S0 !== 4'(m_s0)) begin
            errors++; e_out++;
            if (e_out < 5) $display("FAIL rand_out cyc %0d got %0d exp %0d", i, out_S0, m_s0);
         end
         if (done !== m_done) begin
            errors++; e_done++;
            if (e_done < 5) $display("FAIL rand_done cyc %0d got %0b exp %0b", i, done, m_done);
         end
         if (carry_out !== m_carry()) begin
            errors++; e_carry++;
            if (e_carry < 5) $display("FAIL rand_carry cyc %0d got %0b exp %0b", i, carry_out, m_carry());
         end
         if (disp_S0 !== 4'(m_disp())) begin
            errors++; e_disp++;
            if (e_disp < 5) $display("FAIL rand_disp cyc %0d got %0d exp %0d", i, disp_S0, m_disp());
         end
         tick();
      end
      force_reset = 0; set_en = 0; lap = 0; plus = 0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_limit();
      test_set_mode();
      test_force_on_step();
      test_lap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
